// File: rtl/irrigation_zone_scheduler_pkg.sv
// Shared definitions for the irrigation zone scheduler: FSM state encoding,
// default cycle constants and a small sizing helper.
package irrigation_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_OPEN  = 3'd1,
    ST_WATER = 3'd2,
    ST_CLOSE = 3'd3,
    ST_REST  = 3'd4
  } state_e;

  localparam int DEF_NUM_ZONES     = 4;
  localparam int DEF_SETTLE_CYCLES = 4;
  localparam int DEF_WATER_CYCLES  = 16;
  localparam int DEF_REST_CYCLES   = 8;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/irrigation_zone_scheduler_if.sv
// Sensor-side requests/controls and valve/pump drive of the zone scheduler.
interface irrigation_zone_scheduler_if #(
  parameter int NUM_ZONES = 4
);
  localparam int ZW = $clog2(NUM_ZONES);

  logic                 enable;
  logic                 rain;
  logic [NUM_ZONES-1:0] dry;
  logic [NUM_ZONES-1:0] valve;
  logic                 pump;
  logic                 busy;
  logic [ZW-1:0]        zone;
  logic                 done;
  logic                 abort;

  modport master (
    output enable, rain, dry,
    input  valve, pump, busy, zone, done, abort
  );

  modport slave (
    input  enable, rain, dry,
    output valve, pump, busy, zone, done, abort
  );

endinterface

// File: rtl/irrigation_zone_scheduler_rr_arbiter.sv
// Combinational round-robin search: first set request at or above the pointer,
// wrapping around to zone 0.
module rr_arbiter #(
  parameter int NUM_ZONES = 4,
  localparam int ZW = $clog2(NUM_ZONES)
) (
  input  logic [NUM_ZONES-1:0] req,
  input  logic [ZW-1:0]        ptr,
  output logic                 gnt_vld,
  output logic [ZW-1:0]        gnt_idx
);

  int j;

  // Walk offsets from farthest to nearest so the nearest set request wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    j       = 0;
    for (int i = NUM_ZONES - 1; i >= 0; i--) begin
      j = int'(ptr) + i;
      if (j >= NUM_ZONES) j = j - NUM_ZONES;
      if (req[j]) begin
        gnt_vld = 1'b1;
        gnt_idx = j[ZW-1:0];
      end
    end
  end

endmodule

// File: rtl/irrigation_zone_scheduler.sv
// Shares one pump among NUM_ZONES zones: round-robin grant, then a timed
// open/settle, pump, close, rest sequence for the granted zone's valve.
module irrigation_zone_scheduler
  import irrigation_pkg::*;
#(
  parameter int NUM_ZONES     = DEF_NUM_ZONES,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int WATER_CYCLES  = DEF_WATER_CYCLES,
  parameter int REST_CYCLES   = DEF_REST_CYCLES
) (
  input  logic                           clock,
  input  logic                           reset,
  irrigation_zone_scheduler_if.slave     bus
);

  localparam int ZW = $clog2(NUM_ZONES);
  localparam int TW = $clog2(max3(SETTLE_CYCLES, WATER_CYCLES, REST_CYCLES) + 1);

  state_e               state_q, state_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [ZW-1:0]        ptr_q, ptr_d;
  logic [ZW-1:0]        zone_q, zone_d;
  logic [NUM_ZONES-1:0] valve_q, valve_d;
  logic                 pump_q, pump_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 abort_q, abort_d;
  logic                 aborted_q, aborted_d;

  logic                 ok;
  logic                 gnt_vld;
  logic [ZW-1:0]        gnt_idx;

  assign ok = bus.enable & ~bus.rain;

  rr_arbiter #(.NUM_ZONES(NUM_ZONES)) u_arb (
    .req     (bus.dry),
    .ptr     (ptr_q),
    .gnt_vld (gnt_vld),
    .gnt_idx (gnt_idx)
  );

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    ptr_d     = ptr_q;
    zone_d    = zone_q;
    valve_d   = valve_q;
    pump_d    = pump_q;
    done_d    = 1'b0;
    abort_d   = 1'b0;
    aborted_d = aborted_q;
    case (state_q)
      ST_IDLE: begin
        if (ok && gnt_vld) begin
          zone_d    = gnt_idx;
          ptr_d     = (gnt_idx == ZW'(NUM_ZONES - 1)) ? '0 : gnt_idx + 1'b1;
          valve_d   = '0;
          valve_d[gnt_idx] = 1'b1;
          aborted_d = 1'b0;
          timer_d   = TW'(SETTLE_CYCLES - 1);
          state_d   = ST_OPEN;
        end
      end
      ST_OPEN, ST_WATER: begin
        // Losing ok cuts the grant short but still passes through CLOSE.
        if (!ok) begin
          pump_d    = 1'b0;
          abort_d   = 1'b1;
          aborted_d = 1'b1;
          timer_d   = '0;
          state_d   = ST_CLOSE;
        end else if (timer_q != '0) begin
          timer_d = timer_q - 1'b1;
        end else if (state_q == ST_OPEN) begin
          pump_d  = 1'b1;
          timer_d = TW'(WATER_CYCLES - 1);
          state_d = ST_WATER;
        end else begin
          pump_d  = 1'b0;
          timer_d = '0;
          state_d = ST_CLOSE;
        end
      end
      ST_CLOSE: begin
        valve_d = '0;
        done_d  = ~aborted_q;
        timer_d = TW'(REST_CYCLES - 1);
        state_d = ST_REST;
      end
      ST_REST: begin
        if (timer_q != '0) timer_d = timer_q - 1'b1;
        else               state_d = ST_IDLE;
      end
      default: begin
        valve_d = '0;
        pump_d  = 1'b0;
        timer_d = '0;
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      timer_q   <= '0;
      ptr_q     <= '0;
      zone_q    <= '0;
      valve_q   <= '0;
      pump_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      abort_q   <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      ptr_q     <= ptr_d;
      zone_q    <= zone_d;
      valve_q   <= valve_d;
      pump_q    <= pump_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      abort_q   <= abort_d;
      aborted_q <= aborted_d;
    end
  end

  assign bus.valve = valve_q;
  assign bus.pump  = pump_q;
  assign bus.busy  = busy_q;
  assign bus.zone  = zone_q;
  assign bus.done  = done_q;
  assign bus.abort = abort_q;

endmodule

// File: tb/tb_irrigation_zone_scheduler.sv
// Scoreboard bench: a grant-timeline reference model queues the expected
// outputs for every clock edge; a monitor pops and compares after each edge.
module tb_irrigation_zone_scheduler;

  localparam int N  = 4;
  localparam int ZW = $clog2(N);
  localparam int S  = 4;
  localparam int W  = 16;
  localparam int R  = 8;

  typedef struct packed {
    logic [N-1:0]  valve;
    logic          pump;
    logic          busy;
    logic [ZW-1:0] zone;
    logic          done;
    logic          abort;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  irrigation_zone_scheduler_if #(.NUM_ZONES(N)) bus ();

  irrigation_zone_scheduler #(
    .NUM_ZONES(N), .SETTLE_CYCLES(S), .WATER_CYCLES(W), .REST_CYCLES(R)
  ) dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  obs_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: a grant is a timeline indexed by k, the number of cycles
  // since the grant edge. c is the cycle index at which the valve closes.
  bit            m_active;
  int            m_ptr, m_zone, m_k, m_c;
  bit            m_aborted;

  function automatic obs_t actual();
    obs_t a;
    a.valve = bus.valve; a.pump = bus.pump; a.busy = bus.busy;
    a.zone  = bus.zone;  a.done = bus.done; a.abort = bus.abort;
    return a;
  endfunction

  task automatic check(input string name, input obs_t want, input obs_t got);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s t=%0t got valve=%b pump=%b busy=%b zone=%0d done=%b abort=%b want valve=%b pump=%b busy=%b zone=%0d done=%b abort=%b",
               name, $time, got.valve, got.pump, got.busy, got.zone, got.done, got.abort,
               want.valve, want.pump, want.busy, want.zone, want.done, want.abort);
    end
  endtask

  function automatic obs_t model_out();
    obs_t e;
    e = '0;
    e.zone = ZW'(m_zone);
    if (m_active) begin
      e.busy  = 1'b1;
      if (m_k <= m_c) e.valve[m_zone] = 1'b1;
      e.pump  = (m_k >= S) && (m_k < m_c);
      e.done  = (m_k == m_c + 1) && !m_aborted;
      e.abort = m_aborted && (m_k == m_c);
    end
    return e;
  endfunction

  task automatic model_reset();
    m_active = 0; m_ptr = 0; m_zone = 0; m_k = 0; m_c = 0; m_aborted = 0;
  endtask

  task automatic model_edge(input bit en, input bit rn, input logic [N-1:0] dr);
    bit ok;
    ok = en && !rn;
    if (!m_active) begin
      if (ok && dr != '0) begin
        for (int i = 0; i < N; i++) begin
          if (dr[(m_ptr + i) % N]) begin
            m_zone = (m_ptr + i) % N;
            break;
          end
        end
        m_ptr = (m_zone + 1) % N;
        m_active = 1; m_k = 0; m_c = S + W; m_aborted = 0;
      end
    end else begin
      if (m_k < m_c && !ok) begin
        m_c = m_k + 1;
        m_aborted = 1;
      end
      m_k++;
      if (m_k == m_c + R + 1) m_active = 0;
    end
  endtask

  // One clock of stimulus: drive away from the active edge, predict, enqueue.
  task automatic step(input bit en, input bit rn, input logic [N-1:0] dr);
    @(negedge clk);
    rst_n      = 1'b1;
    bus.enable = en;
    bus.rain   = rn;
    bus.dry    = dr;
    model_edge(en, rn, dr);
    exp_q.push_back(model_out());
  endtask

  initial begin : monitor
    obs_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("cycle", e, actual());
      end
    end
  end

  initial begin : stimulus
    obs_t zero;
    zero = '0;
    model_reset();
    bus.enable = 1'b1;
    bus.rain   = 1'b0;
    bus.dry    = 4'b1111;
    repeat (3) @(posedge clk);
    #1 check("reset_state", zero, actual());

    // Full round robin with every zone dry, then let the last grant finish.
    repeat (125) step(1'b1, 1'b0, 4'b1111);
    repeat (30)  step(1'b1, 1'b0, 4'b0000);
    // Advance the pointer to 3, then a lone request at zone 2 must wrap.
    repeat (60)  step(1'b1, 1'b0, 4'b0110);
    repeat (32)  step(1'b1, 1'b0, 4'b0100);
    repeat (5)   step(1'b1, 1'b0, 4'b0000);

    // Disabled: requests are ignored.
    repeat (20)  step(1'b0, 1'b0, 4'b0011);

    // Rain during WATER aborts the grant.
    repeat (1 + S + 4) step(1'b1, 1'b0, 4'b0001);
    step(1'b1, 1'b1, 4'b0001);
    repeat (3)  step(1'b1, 1'b1, 4'b0000);
    repeat (12) step(1'b1, 1'b0, 4'b0000);

    // Request dropped during OPEN still waters fully.
    repeat (3)  step(1'b1, 1'b0, 4'b0010);
    repeat (40) step(1'b1, 1'b0, 4'b0000);

    // Asynchronous reset in the middle of WATER.
    repeat (1 + S + 6) step(1'b1, 1'b0, 4'b1000);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check("async_reset", zero, actual());
    model_reset();
    @(negedge clk);
    @(negedge clk);
    repeat (35) step(1'b1, 1'b0, 4'b0010);

    // Randomised traffic with occasional disable and rain.
    for (int i = 0; i < 1500; i++) begin
      step(($urandom % 16) != 0, ($urandom % 24) == 0, N'($urandom));
    end

    repeat (3) @(posedge clk);
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog t=%0t got no finish want finish", $time);
    $fatal(1, "timeout");
  end

endmodule
